// File: rtl/cic_serial_pkg.sv
// Shared types and defaults for the CIC sample serializer.
package cic_serial_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} ser_state_t;

    localparam int DATA_WIDTH_DEF = 20;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int SCLK_DIV_DEF   = 2;

    // Counter width for a modulo-v count, never narrower than one bit.
    function automatic int unsigned min1_clog2(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/cic_sample_serializer_fifo.sv
// Small synchronous sample FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module sample_fifo
    import cic_serial_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = FIFO_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PTR_W = min1_clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LVL_W-1:0]      count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // When full, the head is read this cycle before the same slot is overwritten at the edge.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/cic_sample_serializer.sv
// Captures CIC samples into a FIFO and shifts them out MSB-first on sclk/sdata/frame.
// Optional macro SERIALIZER_PARITY_EN appends an even-parity bit after the LSB.
module cic_sample_serializer
    import cic_serial_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int SCLK_DIV   = SCLK_DIV_DEF
) (
    input  logic                              clk_i,
    input  logic                              rstn_i,
    input  logic [DATA_WIDTH-1:0]             sample_data_i,
    input  logic                              sample_clk_i,
    input  logic                              enable_i,
    input  logic                              clear_i,
    output logic                              sclk_o,
    output logic                              sdata_o,
    output logic                              frame_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level_o,
    output logic                              overflow_o
);

`ifdef SERIALIZER_PARITY_EN
    localparam int NBITS = DATA_WIDTH + 1;
`else
    localparam int NBITS = DATA_WIDTH;
`endif
    localparam int CNT_W = $clog2(DATA_WIDTH+2);
    localparam int DIV_W = min1_clog2(SCLK_DIV);

    ser_state_t            state_q, state_d;
    logic                  sample_clk_q;
    logic                  cap_edge;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic [NBITS-1:0]      load_word;
    logic [NBITS-1:0]      shreg;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DIV_W-1:0]      div_cnt;
    logic                  sclk_q;
    logic                  div_last;
    logic                  bit_end;
    logic                  last_bit;
    logic                  overflow_q;

    assign cap_edge = sample_clk_i & ~sample_clk_q;
    assign push     = cap_edge & enable_i;

`ifdef SERIALIZER_PARITY_EN
    assign load_word = {fifo_rd_data, ^fifo_rd_data};
`else
    assign load_word = fifo_rd_data;
`endif

    sample_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst_n   (rstn_i),
        .push    (push),
        .pop     (pop),
        .wr_data (sample_data_i),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level_o)
    );

    // Resets high so a sample clock already high at reset release is not taken as an edge.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) sample_clk_q <= 1'b1;
        else         sample_clk_q <= sample_clk_i;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)                        overflow_q <= 1'b0;
        else if (push & fifo_full & ~pop)   overflow_q <= 1'b1;
        else if (clear_i)                   overflow_q <= 1'b0;
    end

    assign overflow_o = overflow_q;

    assign div_last = (div_cnt == DIV_W'(SCLK_DIV-1));
    assign bit_end  = sclk_q & div_last;
    assign last_bit = (bit_cnt == CNT_W'(NBITS-1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // The last GAP cycle pops the next word directly, keeping back-to-back slots at (NBITS+1) bit periods.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        frame_o = 1'b0;
        sclk_o  = 1'b0;
        sdata_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                frame_o = 1'b1;
                sclk_o  = sclk_q;
                sdata_o = shreg[NBITS-1];
                if (bit_end && last_bit) state_d = GAP;
            end
            GAP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // sclk_q doubles as the half-period phase in GAP, where it is not driven out.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            sclk_q  <= 1'b0;
        end else if (pop) begin
            shreg   <= load_word;
            bit_cnt <= '0;
            div_cnt <= '0;
            sclk_q  <= 1'b0;
        end else if (state_q != IDLE) begin
            if (div_last) begin
                div_cnt <= '0;
                sclk_q  <= ~sclk_q;
                if (sclk_q && state_q == SHIFT) begin
                    shreg   <= {shreg[NBITS-2:0], 1'b0};
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule
